// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_pkg                                                    |
// | Purpose : shared types and constants for the SPI master slice        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int DATA_W          = 8;
  localparam int CLK_DIV_DEFAULT = 4;
  // Two sclk half-periods per data bit.
  localparam int HALF_PERIODS    = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } spiState_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_master_if                                              |
// | Purpose : byte-request handshake and SPI pins of the SPI master      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface spi_master_if;
  import spi_pkg::*;

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              cs;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, tx_data, MISO,
    output rx_data, busy, done, sclk, cs, MOSI
  );

  modport slave (
    output start, tx_data, MISO,
    input  rx_data, busy, done, sclk, cs, MOSI
  );

endinterface
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_clk_gen                                                |
// | Purpose : sclk divider with rise/fall strobes and end-of-frame strobe |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_riseStb,
  output logic o_fallStb,
  output logic o_lastStb
);

  localparam logic [7:0] c_divLast  = 8'(CLK_DIV - 1);
  localparam logic [4:0] c_lastEdge = 5'(HALF_PERIODS);

  logic [7:0] r_divCnt;
  logic [4:0] r_edgeCnt;
  logic       r_sclk;
  logic       w_tick;

  // Strobes fire in the cycle before the boundary edge, so the master
  // updates its registers on the same clk edge that moves sclk.
  assign w_tick    = i_en && (r_divCnt == c_divLast);
  assign o_riseStb = w_tick && (r_edgeCnt != c_lastEdge) && !r_edgeCnt[0];
  assign o_fallStb = w_tick && (r_edgeCnt != c_lastEdge) &&  r_edgeCnt[0];
  assign o_lastStb = w_tick && (r_edgeCnt == c_lastEdge);
  assign o_sclk    = r_sclk;

  always_ff @(posedge clk) begin
    if (!reset || !i_en) begin
      r_divCnt  <= 8'd0;
      r_edgeCnt <= 5'd0;
      r_sclk    <= 1'b0;
    end else if (w_tick) begin
      r_divCnt  <= 8'd0;
      r_edgeCnt <= r_edgeCnt + 5'd1;
      if (o_riseStb || o_fallStb) begin
        r_sclk <= ~r_sclk;
      end
    end else begin
      r_divCnt <= r_divCnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_master                                                 |
// | Purpose : single-byte SPI master; LSB first unless                   |
// |           SPI_MASTER_MSB_FIRST_EN is defined                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);

  spiState_t         r_state;
  spiState_t         w_nextState;
  logic [DATA_W-1:0] r_txShift;
  logic [DATA_W-1:0] r_rxShift;
  logic [DATA_W-1:0] r_rxData;
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_mosi;

  logic              w_clkEn;
  logic              w_sclk;
  logic              w_rise;
  logic              w_fall;
  logic              w_last;
  logic              w_txBit;
  logic [DATA_W-1:0] w_txNext;
  logic [DATA_W-1:0] w_rxNext;

  assign w_clkEn = (r_state == SETUP) || (r_state == TRANSFER);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkGen (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_clkEn),
    .o_sclk    (w_sclk),
    .o_riseStb (w_rise),
    .o_fallStb (w_fall),
    .o_lastStb (w_last)
  );

`ifdef SPI_MASTER_MSB_FIRST_EN
  assign w_txBit  = r_txShift[DATA_W-1];
  assign w_txNext = {r_txShift[DATA_W-2:0], 1'b0};
  assign w_rxNext = {r_rxShift[DATA_W-2:0], bus.MISO};
`else
  assign w_txBit  = r_txShift[0];
  assign w_txNext = {1'b0, r_txShift[DATA_W-1:1]};
  assign w_rxNext = {bus.MISO, r_rxShift[DATA_W-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (bus.start) w_nextState = SETUP;
      SETUP:    if (w_rise)    w_nextState = TRANSFER;
      TRANSFER: if (w_last)    w_nextState = DONE;
      DONE:                    w_nextState = IDLE;
      default:                 w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_txShift <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == IDLE) && bus.start) begin
        r_txShift <= bus.tx_data;
        r_rxShift <= '0;
        r_busy    <= 1'b1;
        r_cs      <= 1'b0;
      end
      if (w_rise) begin
        r_mosi    <= w_txBit;
        r_txShift <= w_txNext;
      end
      if (w_fall) begin
        r_rxShift <= w_rxNext;
      end
      // rx_data only ever takes a complete frame.
      if (w_last) begin
        r_done   <= 1'b1;
        r_cs     <= 1'b1;
        r_rxData <= r_rxShift;
      end
      if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.rx_data = r_rxData;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sclk    = w_sclk;
  assign bus.cs      = r_cs;
  assign bus.MOSI    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_master                                              |
// | Purpose : scoreboard bench for spi_master against a shift-reg slave   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_master;

  localparam int DIV        = 1;
  localparam int XFER_CYC   = 17 * DIV;
  localparam int WAIT_LIMIT = 40 * DIV + 40;
`ifdef SPI_MASTER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  spi_master_if bus ();

  spi_master #(
    .CLK_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: drives MISO on sclk rise, samples MOSI on sclk fall.
  logic [7:0] slaveInit = 8'h09;
  logic [7:0] slaveReg  = 8'h09;
  logic       misoBit   = 1'b0;
  assign bus.MISO = misoBit;

  always @(posedge bus.sclk, negedge bus.sclk, negedge reset) begin
    if (!reset) begin
      slaveReg <= slaveInit;
      misoBit  <= 1'b0;
    end else if (bus.sclk) begin
      misoBit <= MSB_FIRST ? slaveReg[7] : slaveReg[0];
    end else begin
      slaveReg <= MSB_FIRST ? {slaveReg[6:0], bus.MOSI} : {bus.MOSI, slaveReg[7:1]};
    end
  end

  // Monitor: outputs set by posedge k are sampled at the following negedge (cyc == k).
  int         accCyc      = 0;
  int         lastDoneCyc = -100;
  int         riseCnt     = 0;
  int         csLowCnt    = 0;
  int         firstRise   = -1;
  logic       inFlight    = 1'b0;
  logic       prevSclk    = 1'b0;
  logic       prevBusy    = 1'b0;
  logic       busyDrop    = 1'b0;
  logic       b2bExpect   = 1'b0;
  logic [7:0] mosiByte    = 8'h00;
  exp_t       cur;

  always @(negedge clk) begin
    if (!reset) begin
      inFlight = 1'b0;
      busyDrop = 1'b0;
      prevSclk = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (busyDrop) begin
        check("busy low after done", int'(bus.busy), 0);
        busyDrop = 1'b0;
      end
      if (bus.busy && !prevBusy) begin
        if (b2bExpect) check("back-to-back accept gap", cyc - lastDoneCyc, 2);
        inFlight  = 1'b1;
        accCyc    = cyc;
        riseCnt   = 0;
        csLowCnt  = 0;
        firstRise = -1;
        mosiByte  = 8'h00;
      end
      if (inFlight) begin
        if (!bus.cs) csLowCnt++;
        if (bus.sclk && !prevSclk) begin
          if (riseCnt == 0) firstRise = cyc - accCyc;
          riseCnt++;
          mosiByte = MSB_FIRST ? {mosiByte[6:0], bus.MOSI} : {bus.MOSI, mosiByte[7:1]};
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("done with empty scoreboard", 1, 0);
          end else begin
            cur = sb.pop_front();
            check("rx_data at done", int'(bus.rx_data), int'(cur.rx));
            check("MOSI byte", int'(mosiByte), int'(cur.tx));
            check("slave register", int'(slaveReg), int'(cur.tx));
            check("done latency", cyc - accCyc, XFER_CYC);
            check("cs low cycles", csLowCnt, XFER_CYC);
            check("sclk rising edges", riseCnt, 8);
            check("first sclk rise delay", firstRise, DIV);
            check("busy at done", int'(bus.busy), 1);
            check("cs at done", int'(bus.cs), 1);
            check("sclk at done", int'(bus.sclk), 0);
          end
          inFlight    = 1'b0;
          lastDoneCyc = cyc;
          busyDrop    = 1'b1;
        end
      end else if (bus.done) begin
        check("done outside a transfer", 1, 0);
      end
      prevSclk = bus.sclk;
      prevBusy = bus.busy;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle within bound", int'(bus.busy), 0);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!bus.done && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("done within bound", int'(bus.done), 1);
  endtask

  task automatic issue(input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    waitIdle();
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(posedge clk);
    e.tx = tx;
    e.rx = rx;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int   rises;
  int   n2;
  logic p;
  exp_t e2;

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b1;
    bus.tx_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cs", int'(bus.cs), 1);
    check("reset sclk", int'(bus.sclk), 0);
    check("reset MOSI", int'(bus.MOSI), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset rx_data", int'(bus.rx_data), 'h00);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    issue(8'h82, 8'h09);
    waitDone();
    issue(8'hA0, 8'h82);
    waitDone();

    // Second start mid-frame must be dropped.
    issue(8'h3C, 8'hA0);
    repeat (8 * DIV) @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone();

    // start held high: second frame follows immediately after DONE.
    waitIdle();
    bus.tx_data = 8'h5A;
    bus.start   = 1'b1;
    @(posedge clk);
    e2.tx = 8'h5A; e2.rx = 8'h3C; sb.push_back(e2);
    e2.tx = 8'hC3; e2.rx = 8'h5A; sb.push_back(e2);
    @(negedge clk);
    bus.tx_data = 8'hC3;
    waitDone();
    b2bExpect = 1'b1;
    waitIdle();
    n2 = 0;
    while (!bus.busy && n2 < WAIT_LIMIT) begin
      @(negedge clk);
      n2++;
    end
    check("second accept within bound", int'(bus.busy), 1);
    bus.start = 1'b0;
    @(negedge clk);
    b2bExpect = 1'b0;
    waitDone();

    // Abort after the third rising sclk edge.
    waitIdle();
    bus.tx_data = 8'h11;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rises = 0;
    p     = bus.sclk;
    n2    = 0;
    while (rises < 3 && n2 < WAIT_LIMIT) begin
      @(negedge clk);
      n2++;
      if (bus.sclk && !p) rises++;
      p = bus.sclk;
    end
    check("third sclk rise reached", rises, 3);
    slaveInit = 8'h0F;
    reset     = 1'b0;
    @(negedge clk);
    check("abort cs", int'(bus.cs), 1);
    check("abort sclk", int'(bus.sclk), 0);
    check("abort rx_data", int'(bus.rx_data), 'h00);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b1;

    issue(8'hF0, 8'h0F);
    waitDone();

    repeat (10) @(negedge clk);
    check("rx_data held while idle", int'(bus.rx_data), 'h0F);
    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-low reset.
REQ-004 Port start  input  1  request one 8-bit transfer; sampled only in IDLE.
REQ-005 Port tx_data  input  8  byte to send; latched when start is accepted.
REQ-006 Port rx_data  output  8  last fully received byte.
REQ-007 Port busy  output  1  high from accept through the done cycle inclusive.
REQ-008 Port done  output  1  one-cycle pulse at end of transfer.
REQ-009 Port sclk  output  1  SPI clock to slave clk; idles low.
REQ-010 Port cs  output  1  chip select to slave, active low.
REQ-011 Port MOSI  output  1  serial data to slave.
REQ-012 Port MISO  input  1  serial data from slave.

Function
REQ-013 FSM states: IDLE, SETUP, TRANSFER, DONE; outputs are registered.
REQ-014 IDLE->SETUP on start=1 at edge N; tx_data latched into shift register; busy=1 and cs=0 from N+1.
REQ-015 SETUP: sclk low for CLK_DIV cycles, then ->TRANSFER.
REQ-016 TRANSFER: 16 half-periods of CLK_DIV cycles each; sclk toggles at each boundary, starting with a rising edge.
REQ-017 On rising sclk edge k (k=0..7): MOSI = tx bit k (LSB first); the transmit shift register shifts right.
REQ-018 On falling sclk edge k: MISO captured into bit 7 of the receive shift register after shift right, so the first received bit ends at bit 0.
REQ-019 After the 8th falling edge ->DONE: done=1 and rx_data updated in the same cycle; cs=1, sclk=0; busy falls the next cycle; ->IDLE.
REQ-020 Latency: done asserts at N+1+17*CLK_DIV (CLK_DIV=1: N+18).
REQ-021 start in SETUP, TRANSFER or DONE is ignored (not queued); back-to-back start accepted in the first IDLE cycle after DONE.
REQ-022 tx_data changes after accept have no effect on the current transfer.
REQ-023 rx_data holds its value between transfers; it is never partially updated.
REQ-024 The divider counter is 8 bits, reloads at each half-period boundary, and never wraps mid half-period.

Reset
REQ-025 reset=0 at any edge: state=IDLE, cs=1, sclk=0, MOSI=0, busy=0, done=0, rx_data=8'h00, counters and shift registers cleared.
REQ-026 reset mid-transfer aborts without a done pulse; rx_data returns to 8'h00.

Configuration
REQ-027 Macro SPI_MASTER_MSB_FIRST_EN defined: transmit and receive are MSB first (MOSI = bit 7-k; MISO shifts in at bit 0, shifting left).
REQ-028 Macro SPI_MASTER_MSB_FIRST_EN undefined: LSB first per REQ-017/REQ-018; timing identical in both modes.

Structure
REQ-029 Package spi_pkg holds the state enum, DATA_W=8, and CLK_DIV_DEFAULT=4.
REQ-030 Sub-module spi_clk_gen: divider producing sclk plus one-cycle rise/fall strobes; enabled only in SETUP/TRANSFER.

Verification
REQ-031 Bench connects spi_master to the team's Slave (initialValue 8'h09); tx_data=8'h82 -> rx_data=8'h09 at done; slave register reads 8'h82.
REQ-032 CLK_DIV=1, start at edge N -> done at N+18 exactly; busy high N+1..N+18; cs low N+1..N+17.
REQ-033 start pulsed again at half-transfer with tx_data=8'hFF -> ignored; one done pulse; MOSI sequence follows the first byte.
REQ-034 reset=0 after the 3rd rising sclk edge -> cs=1, sclk=0, rx_data=8'h00 next cycle; no done; a new transfer of 8'hF0/8'h0F then completes correctly.
REQ-035 SPI_MASTER_MSB_FIRST_EN defined, tx_data=8'hA0 -> MOSI at rising edges 1,0,1,0,0,0,0,0; undefined -> 0,0,0,0,0,1,0,1.
REQ-036 Back-to-back: start held high -> second transfer accepted in the IDLE cycle after DONE; sclk stays low for CLK_DIV cycles before its first rising edge.
